uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Parametrised UART transmitter core. It combines the control FSM, serializer, parity generator and line mux in one block, and is the successor to the fixed 8-bit single-stop TX FSM. It adds configurable data width, runtime even/odd parity, one or two stop bits, and a baud-tick enable input. It sits between the system bus / TX FIFO and the serial pin; the baud generator drives tick.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
IDLE_LEVEL, 1'b1, line level in idle and stop bits; the start bit is ~IDLE_LEVEL.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
tick  input  1  baud enable, one clk wide, once per bit period
data_valid  input  1  request to send p_data
p_data  input  DATA_WIDTH  parallel data, LSB transmitted first
par_en  input  1  1 = append parity bit
par_typ  input  1  0 = even, 1 = odd
two_stop  input  1  1 = two stop bits, 0 = one
tx_out  output  1  serial line, registered
busy  output  1  frame in progress, registered

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, tx_out=IDLE_LEVEL, busy=0, bit counter 0, shift register 0.
- Reset mid-frame aborts the frame. The line returns to IDLE_LEVEL immediately and no partial resume occurs.
- Accept: in IDLE with data_valid=1, capture p_data, par_en, par_typ and two_stop. busy=1 from the next clk.
  - While busy=1, data_valid is ignored and configuration input changes have no effect on the frame in flight.
- FSM states: IDLE, ARMED, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> ARMED on accept.
  - ARMED -> START on the first tick cycle after acceptance. A tick coincident with the accept cycle does not count.
  - START -> DATA on tick.
  - DATA -> DATA on tick while bit counter < DATA_WIDTH-1, incrementing the counter and shifting right.
  - DATA -> PARITY on tick at the last bit if par_en, else DATA -> STOP1.
  - PARITY -> STOP1 on tick.
  - STOP1 -> STOP2 on tick if two_stop, else STOP1 -> IDLE.
  - STOP2 -> IDLE on tick.
- Bit timing: each START/DATA/PARITY/STOP bit spans exactly one tick interval. The bit is entered on a tick cycle and held until the next tick cycle.
- Frame length in ticks: 1 + DATA_WIDTH + par_en + 1 + two_stop.
- tx_out is registered and reflects the current state:
  - IDLE/ARMED/STOP1/STOP2: IDLE_LEVEL.
  - START: ~IDLE_LEVEL.
  - DATA: shift_reg[0].
  - PARITY: computed bit.
- Parity: even = XOR-reduce of captured data; odd = its inverse. Computed once at accept.
- busy:
  - Drops to 0 on the clk after the final stop-bit tick (state returns to IDLE).
  - A new data_valid in that same IDLE cycle is accepted, giving back-to-back frames with a gap of at most one tick interval (the ARMED wait).
- Bit counter width is $clog2(DATA_WIDTH). The counter never wraps within a frame and clears on entry to START.
- tick held high continuously is legal: one bit per clk.

Optional Feature:
Macro UART_TX_DONE_PULSE_EN.
- Defined: adds output tx_done (1 bit, reset 0). It pulses high for exactly one clk on the cycle the FSM returns to IDLE from the final stop bit.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package uart_tx_pkg holds:
  - state typedef (7 encoded states)
  - parity type constants PAR_EVEN=0, PAR_ODD=1
  - localparam for the default DATA_WIDTH
- One sub-module: uart_tx_parity (DATA_WIDTH-wide data plus par_typ in, 1-bit parity out), purely combinational and instantiated once.
- FSM, shift register and counter stay in uart_tx_engine.

Test Plan:
1. tick every clk, DATA_WIDTH=8, p_data=0xA5, par_en=0, two_stop=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 (10 bits); busy high for exactly 11 clks.
2. tick every 4 clks, p_data=0x0F, par_en=1, par_typ=0 -> even parity bit=0 sent after bit 7. par_typ=1 -> parity bit=1. Each bit lasts 4 clks.
3. two_stop=1, par_en=1, DATA_WIDTH=5, p_data=0x13 -> frame is 1+5+1+2=9 tick intervals; two stop bits at IDLE_LEVEL; busy falls after the second stop bit.
4. data_valid pulsed with p_data=0x55 at mid-frame of 0xAA -> 0x55 ignored, 0xAA frame intact. data_valid held on the busy-fall cycle -> second frame starts at the next tick.
5. rst asserted during DATA bit 3 -> tx_out=1 and busy=0 asynchronously. After release with no data_valid, tx_out stays 1.
6. UART_TX_DONE_PULSE_EN defined -> tx_done single-clk pulse coincident with the return to IDLE, once per frame, including back-to-back frames.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding, parity selectors and default frame width for the UART transmitter.
package uart_tx_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: combinational even/odd parity over one data word.
module uart_tx_parity
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    assign parity = (par_typ == PAR_EVEN) ? ^data : ~^data;

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: parametrised UART transmitter (start, 5..9 data bits LSB first, optional parity, 1 or 2 stops).
// Define UART_TX_DONE_PULSE_EN to add the tx_done one-clk end-of-frame pulse.
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int   DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  two_stop,
    output logic                  tx_out,
    output logic                  busy
`ifdef UART_TX_DONE_PULSE_EN
    ,
    output logic                  tx_done
`endif
);

    localparam int              CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  par_en_q, two_stop_q, par_bit_q;
    logic                  par_bit;
    logic                  accept;
    logic                  tx_n;

    assign accept = (state == IDLE) && data_valid;

    uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data    (p_data),
        .par_typ (par_typ),
        .parity  (par_bit)
    );

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        cnt_n   = cnt;
        case (state)
            IDLE: if (data_valid) begin
                state_n = ARMED;
                shift_n = p_data;
            end
            ARMED: if (tick) begin
                state_n = START;
                cnt_n   = '0;
            end
            START: if (tick) state_n = DATA;
            DATA: if (tick) begin
                if (cnt < LAST) begin
                    cnt_n   = cnt + 1'b1;
                    shift_n = shift_reg >> 1;
                end else begin
                    state_n = par_en_q ? PARITY : STOP1;
                end
            end
            PARITY: if (tick) state_n = STOP1;
            STOP1:  if (tick) state_n = two_stop_q ? STOP2 : IDLE;
            STOP2:  if (tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // line level is registered from the state being entered so it changes with the bit boundary
        tx_n = (state_n == START)  ? ~IDLE_LEVEL :
               (state_n == DATA)   ? shift_n[0]  :
               (state_n == PARITY) ? par_bit_q   : IDLE_LEVEL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            cnt        <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_out     <= IDLE_LEVEL;
            busy       <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            cnt       <= cnt_n;
            tx_out    <= tx_n;
            busy      <= (state_n != IDLE);
            if (accept) begin
                par_en_q   <= par_en;
                two_stop_q <= two_stop;
                par_bit_q  <= par_bit;
            end
        end
    end

`ifdef UART_TX_DONE_PULSE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_done <= 1'b0;
        else      tx_done <= (state != IDLE) && (state_n == IDLE);
    end
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: table-driven, hand-sequenced and random checks of uart_tx_engine against a frame-level model.
module tb_uart_tx_engine;

    typedef bit bitq_t[$];

    typedef struct {
        logic [7:0] d;
        bit         pe;
        bit         pt;
        bit         ts;
        int         per;
        int         len;
        bit         par;
    } vec_t;

    logic       clk = 0, rst = 0, tick = 0, data_valid = 0, data_valid5 = 0;
    logic [7:0] p_data = 0;
    logic [4:0] p_data5 = 0;
    logic       par_en = 0, par_typ = 0, two_stop = 0;
    logic       tx_out8, busy8, tx_out5, busy5;
`ifdef UART_TX_DONE_PULSE_EN
    logic       tx_done8, tx_done5;
    int         done_cnt = 0, done5_cnt = 0;
`endif

    int    checks = 0, failures = 0;
    int    period = 1, pcnt = 0, n = 0, bc8 = 0, bc5 = 0;
    bitq_t cap8, cap5, mq;
    bit    m_busy = 0, m_line = 1, m_done = 0, tick_edge = 0, pb8 = 0, pb5 = 0;
    vec_t  tbl[6];
    logic [7:0] rd;
    bit    rpe, rpt, rts;

    uart_tx_engine #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .tick(tick), .data_valid(data_valid), .p_data(p_data),
        .par_en(par_en), .par_typ(par_typ), .two_stop(two_stop), .tx_out(tx_out8), .busy(busy8)
`ifdef UART_TX_DONE_PULSE_EN
        , .tx_done(tx_done8)
`endif
    );

    uart_tx_engine #(.DATA_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .tick(tick), .data_valid(data_valid5), .p_data(p_data5),
        .par_en(par_en), .par_typ(par_typ), .two_stop(two_stop), .tx_out(tx_out5), .busy(busy5)
`ifdef UART_TX_DONE_PULSE_EN
        , .tx_done(tx_done5)
`endif
    );

    always #5 clk = ~clk;

    // Expected on-line bit sequence of a frame: start, data LSB first, parity, stop(s).
    function automatic bitq_t frame_bits(input int w, input logic [8:0] d, input bit pe, input bit pt, input bit ts);
        bitq_t q;
        bit p = pt;
        q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            q.push_back(d[i]);
            p ^= d[i];
        end
        if (pe) q.push_back(p);
        q.push_back(1'b1);
        if (ts) q.push_back(1'b1);
        return q;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_frame(input string nm, input bitq_t got, input bitq_t exp);
        logic [15:0] g = '0, x = '0;
        foreach (got[i]) if (i < 16) g[i] = got[i];
        foreach (exp[i]) if (i < 16) x[i] = exp[i];
        chk({nm, "_len"}, got.size(), exp.size());
        chk(nm, {16'h0, g}, {16'h0, x});
    endtask

    initial forever begin
        @(negedge clk);
        tick = (pcnt == 0);
        pcnt = (pcnt + 1 >= period) ? 0 : pcnt + 1;
    end

    // Frame-level model: a frame is a queue of line bits, one popped per tick once accepted.
    initial forever begin
        @(posedge clk or negedge rst);
        m_done    = 0;
        tick_edge = 0;
        if (!rst) begin
            m_busy = 0;
            m_line = 1;
            mq.delete();
        end else begin
            tick_edge = tick;
            if (!m_busy) begin
                if (data_valid) begin
                    mq     = frame_bits(8, {1'b0, p_data}, par_en, par_typ, two_stop);
                    m_busy = 1;
                end
            end else if (tick) begin
                if (mq.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_line = mq.pop_front();
                end
            end
            if (!m_busy) m_line = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("line", tx_out8, m_line);
        chk("busy", busy8, m_busy);
`ifdef UART_TX_DONE_PULSE_EN
        chk("done", tx_done8, m_done);
        if (tx_done8) done_cnt++;
        if (tx_done5) done5_cnt++;
`endif
        if (tick_edge && pb8 && busy8) cap8.push_back(tx_out8);
        if (tick_edge && pb5 && busy5) cap5.push_back(tx_out5);
        if (busy8) bc8++;
        if (busy5) bc5++;
        pb8 = busy8;
        pb5 = busy5;
    end

    task automatic wait_idle8(input int budget);
        int k = 0;
        while (busy8 && k < budget) begin
            @(negedge clk);
            k++;
            p_data     = 8'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
            two_stop   = 1'($urandom);
            data_valid = busy8 ? 1'($urandom) : 1'b0;
        end
        data_valid = 0;
        chk("idle_timeout8", busy8, 0);
    endtask

    task automatic send8(input logic [7:0] d, input bit pe, input bit pt, input bit ts, input int per);
        period = per;
        @(negedge clk);
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; two_stop = ts; data_valid = 1;
        cap8.delete();
        bc8 = 0;
        @(negedge clk);
        data_valid = 0;
        wait_idle8(16 * per + 8);
    endtask

    task automatic run_row(input vec_t v);
        send8(v.d, v.pe, v.pt, v.ts, v.per);
        chk("row_len", cap8.size(), v.len);
        cmp_frame("row_frame", cap8, frame_bits(8, {1'b0, v.d}, v.pe, v.pt, v.ts));
        if (v.pe) chk("row_par", cap8[9], v.par);
        chk("row_busy_span", (bc8 > v.len * v.per && bc8 <= v.len * v.per + v.per), 1);
        if (v.per == 1) chk("row_busy_exact", bc8, v.len + 1);
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1, 10, 1'b0};
        tbl[1] = '{8'h0F, 1'b1, 1'b0, 1'b0, 4, 11, 1'b0};
        tbl[2] = '{8'h0F, 1'b1, 1'b1, 1'b0, 4, 11, 1'b1};
        tbl[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 2, 12, 1'b1};
        tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 3, 11, 1'b0};
        tbl[5] = '{8'h07, 1'b1, 1'b0, 1'b1, 1, 12, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_line8", tx_out8, 1);
        chk("rst_busy8", busy8, 0);
        chk("rst_line5", tx_out5, 1);
        chk("rst_busy5", busy5, 0);
`ifdef UART_TX_DONE_PULSE_EN
        chk("rst_done8", tx_done8, 0);
`endif
        rst = 1;

        for (int r = 0; r < 6; r++) run_row(tbl[r]);

        // width-5 frame with parity and two stops; config changes after accept must not matter
        period = 2;
        @(negedge clk);
        @(negedge clk);
        p_data5 = 5'h13; par_en = 1; par_typ = 0; two_stop = 1; data_valid5 = 1;
        cap5.delete();
        bc5 = 0;
        @(negedge clk);
        data_valid5 = 0; par_en = 0; par_typ = 1; two_stop = 0;
        n = 0;
        while (busy5 && n < 100) begin @(negedge clk); n++; end
        chk("w5_idle", busy5, 0);
        cmp_frame("w5_frame", cap5, frame_bits(5, 9'h013, 1, 0, 1));
        chk("w5_par", cap5[6], 1);
        chk("w5_stops", {30'h0, cap5[7], cap5[8]}, 3);
        chk("w5_busy_span", (bc5 > 18 && bc5 <= 20), 1);
`ifdef UART_TX_DONE_PULSE_EN
        chk("w5_done_count", done5_cnt, 1);
`endif

        // mid-frame request ignored, then held into the idle cycle for a back-to-back frame
        period = 3;
        @(negedge clk);
        @(negedge clk);
        p_data = 8'hAA; par_en = 0; par_typ = 0; two_stop = 0; data_valid = 1;
        cap8.delete();
`ifdef UART_TX_DONE_PULSE_EN
        done_cnt = 0;
`endif
        @(negedge clk);
        data_valid = 0;
        n = 0;
        while (cap8.size() < 5 && n < 100) begin @(negedge clk); n++; end
        p_data = 8'h55; par_en = 1; par_typ = 1; two_stop = 1; data_valid = 1;
        n = 0;
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        chk("b2b_gap_idle", busy8, 0);
        cmp_frame("b2b_first", cap8, frame_bits(8, 9'h0AA, 0, 0, 0));
        cap8.delete();
        @(negedge clk);
        data_valid = 0;
        chk("b2b_rearm", busy8, 1);
        wait_idle8(100);
        cmp_frame("b2b_second", cap8, frame_bits(8, 9'h055, 1, 1, 1));
`ifdef UART_TX_DONE_PULSE_EN
        chk("b2b_done_count", done_cnt, 2);
`endif

        // asynchronous reset in data bit 3 of 0xA5 (a 0 bit)
        period = 2;
        @(negedge clk);
        @(negedge clk);
        p_data = 8'hA5; par_en = 0; par_typ = 0; two_stop = 0; data_valid = 1;
        cap8.delete();
        @(negedge clk);
        data_valid = 0;
        n = 0;
        while (cap8.size() < 5 && n < 100) begin @(negedge clk); n++; end
        chk("pre_rst_line", tx_out8, 0);
        #2 rst = 0;
        #1;
        chk("rst_async_line", tx_out8, 1);
        chk("rst_async_busy", busy8, 0);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {30'h0, tx_out8, busy8}, 2);
        end

        for (int k = 0; k < 40; k++) begin
            rd  = 8'($urandom);
            rpe = 1'($urandom);
            rpt = 1'($urandom);
            rts = 1'($urandom);
            send8(rd, rpe, rpt, rts, int'($urandom_range(1, 5)));
            cmp_frame("rand_frame", cap8, frame_bits(8, {1'b0, rd}, rpe, rpt, rts));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
